// File: rtl/counter_ctrl_if.sv
// Button inputs and counter strobes between the LED counter front-end and its surroundings.
// master drives the raw buttons and observes the strobes; slave is the controller side.
interface counter_ctrl_if;
  logic       i_btn_step;
  logic       i_btn_mode;
  logic       i_btn_clr;
  logic       o_cnt_en;
  logic       o_cnt_up;
  logic       o_cnt_clr;
  logic [1:0] o_mode;

  modport master (
    output i_btn_step, i_btn_mode, i_btn_clr,
    input  o_cnt_en, o_cnt_up, o_cnt_clr, o_mode
  );

  modport slave (
    input  i_btn_step, i_btn_mode, i_btn_clr,
    output o_cnt_en, o_cnt_up, o_cnt_clr, o_mode
  );
endinterface

// File: rtl/counter_ctrl.sv
// Button conditioning (sync, debounce, edge) plus mode FSM sequencing the 3-bit LED counter.
// Latency DEBOUNCE_CYCLES+2 edges from first sampled press; no backpressure, strobes are fire-and-forget.
module counter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_DIV        = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  counter_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(AUTO_DIV);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(AUTO_DIV - 1);

  localparam int BTN_STEP = 0;
  localparam int BTN_MODE = 1;
  localparam int BTN_CLR  = 2;

  typedef enum logic [1:0] {
    MODE_STEP     = 2'b00,
    MODE_RUN_UP   = 2'b01,
    MODE_RUN_DOWN = 2'b10,
    MODE_ILLEGAL  = 2'b11
  } mode_e;

  logic [2:0]    btn_raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    filt;
  logic [2:0]    filt_q;
  logic [2:0]    press;
  logic [DW-1:0] db_cnt [3];

  mode_e         mode_q, mode_d;
  logic          up_q, up_d;
  logic          en_q, en_d;
  logic          clr_q, clr_d;
  logic [PW-1:0] presc_q, presc_d;

  assign btn_raw = {bus.i_btn_clr, bus.i_btn_mode, bus.i_btn_step};

  // Filtered level only flips after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      filt   <= '0;
      filt_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1  <= btn_raw;
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= ~filt[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = filt & ~filt_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mode_q  <= MODE_STEP;
      up_q    <= 1'b1;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      presc_q <= '0;
    end else begin
      mode_q  <= mode_d;
      up_q    <= up_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      presc_q <= presc_d;
    end
  end

  // Press priority clr > mode > step; losing presses in the same cycle are dropped.
  always_comb begin
    mode_d  = mode_q;
    en_d    = 1'b0;
    clr_d   = 1'b0;
    presc_d = presc_q;
    if (mode_q == MODE_ILLEGAL) begin
      mode_d  = MODE_STEP;
      presc_d = '0;
    end else if (press[BTN_CLR]) begin
      clr_d   = 1'b1;
      mode_d  = MODE_STEP;
      presc_d = '0;
    end else begin
      case (mode_q)
        MODE_STEP: begin
          presc_d = '0;
          if (press[BTN_MODE]) begin
            mode_d = MODE_RUN_UP;
          end else if (press[BTN_STEP]) begin
            en_d = 1'b1;
          end
        end
        MODE_RUN_UP, MODE_RUN_DOWN: begin
          if (press[BTN_MODE]) begin
            mode_d  = (mode_q == MODE_RUN_UP) ? MODE_RUN_DOWN : MODE_STEP;
            presc_d = '0;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            en_d    = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          mode_d  = MODE_STEP;
          presc_d = '0;
        end
      endcase
    end
    up_d = (mode_d != MODE_RUN_DOWN);
  end

  assign bus.o_cnt_en  = en_q;
  assign bus.o_cnt_up  = up_q;
  assign bus.o_cnt_clr = clr_q;
  assign bus.o_mode    = mode_q;

  a_en_clr_exclusive: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(en_q && clr_q));
  a_mode_legal: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    mode_q != MODE_ILLEGAL);

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: table of button patterns with expected pulse counts,
// plus hand-written sequences for exact latency, clr/mode collision and reset while held.
module tb_counter_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  counter_ctrl_if bus();

  counter_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_DIV(8)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int both_cnt = 0;

  typedef struct {
    logic [2:0] btn;      // {clr, mode, step}
    int         high;
    int         low;
    int         reps;
    int         run;
    int         exp_en;
    int         exp_clr;
    logic [1:0] exp_mode;
    logic       exp_up;
  } vec_t;

  vec_t vecs [7];

  task automatic set_btn(input logic [2:0] b);
    bus.i_btn_step = b[0];
    bus.i_btn_mode = b[1];
    bus.i_btn_clr  = b[2];
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.o_cnt_en) en_cnt++;
    if (bus.o_cnt_clr) clr_cnt++;
    if (bus.o_cnt_en && bus.o_cnt_clr) both_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " en"},   int'(bus.o_cnt_en),  0);
    chk({tag, " clr"},  int'(bus.o_cnt_clr), 0);
    chk({tag, " mode"}, int'(bus.o_mode),    0);
    chk({tag, " up"},   int'(bus.o_cnt_up),  1);
  endtask

  initial begin
    // Phases below are hand-computed: a press set just after tick c shows its strobe at tick c+7,
    // auto pulses land 8 ticks apart starting 8 ticks after the mode change.
    vecs[0] = '{3'b001, 20, 20, 10,  0, 10, 0, 2'b00, 1'b1};
    vecs[1] = '{3'b001,  2, 10,  1,  0,  0, 0, 2'b00, 1'b1};
    vecs[2] = '{3'b001,  3,  2,  8,  0,  0, 0, 2'b00, 1'b1};
    vecs[3] = '{3'b010, 20, 20,  1, 51, 10, 0, 2'b01, 1'b1};
    vecs[4] = '{3'b001, 20, 20,  2,  0, 10, 0, 2'b01, 1'b1};
    vecs[5] = '{3'b010, 20, 20,  1, 43, 10, 0, 2'b10, 1'b0};
    vecs[6] = '{3'b010, 20, 20,  1, 50,  1, 0, 2'b00, 1'b1};

    rst_n = 1'b0;
    set_btn(3'b000);
    ticks(3);
    chk_idle("reset");
    rst_n = 1'b1;
    ticks(5);

    // Exact latency and single-cycle width of a step strobe.
    en_cnt = 0;
    set_btn(3'b001);
    ticks(6);
    chk("lat_early", int'(bus.o_cnt_en), 0);
    tick();
    chk("lat_exact", int'(bus.o_cnt_en), 1);
    chk("lat_up", int'(bus.o_cnt_up), 1);
    tick();
    chk("lat_width", int'(bus.o_cnt_en), 0);
    ticks(17);
    set_btn(3'b000);
    ticks(20);
    chk("lat_count", en_cnt, 1);

    for (int v = 0; v < 7; v++) begin
      en_cnt  = 0;
      clr_cnt = 0;
      for (int r = 0; r < vecs[v].reps; r++) begin
        set_btn(vecs[v].btn);
        ticks(vecs[v].high);
        set_btn(3'b000);
        ticks(vecs[v].low);
      end
      ticks(vecs[v].run);
      chk($sformatf("vec%0d en_pulses", v),  en_cnt,               vecs[v].exp_en);
      chk($sformatf("vec%0d clr_pulses", v), clr_cnt,              vecs[v].exp_clr);
      chk($sformatf("vec%0d mode", v),       int'(bus.o_mode),     int'(vecs[v].exp_mode));
      chk($sformatf("vec%0d up", v),         int'(bus.o_cnt_up),   int'(vecs[v].exp_up));
    end

    // mode+clr together in RUN_UP, timed so the clr lands on an auto-pulse slot.
    set_btn(3'b010);
    ticks(20);
    set_btn(3'b000);
    ticks(20);
    chk("prio_run_up", int'(bus.o_mode), 1);
    set_btn(3'b110);
    ticks(6);
    chk("prio_clr_early", int'(bus.o_cnt_clr), 0);
    tick();
    chk("prio_clr", int'(bus.o_cnt_clr), 1);
    chk("prio_en_low", int'(bus.o_cnt_en), 0);
    chk("prio_mode", int'(bus.o_mode), 0);
    en_cnt  = 0;
    clr_cnt = 0;
    ticks(13);
    set_btn(3'b000);
    ticks(30);
    chk("prio_after_en", en_cnt, 0);
    chk("prio_after_clr", clr_cnt, 0);
    chk("prio_after_mode", int'(bus.o_mode), 0);

    // Reset pulse in RUN_DOWN while step is held.
    for (int p = 0; p < 2; p++) begin
      set_btn(3'b010);
      ticks(20);
      set_btn(3'b000);
      ticks(20);
    end
    chk("rd_mode", int'(bus.o_mode), 2);
    chk("rd_up", int'(bus.o_cnt_up), 0);
    set_btn(3'b001);
    ticks(10);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_async");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_idle($sformatf("rst_hold%0d", c));
    end
    rst_n = 1'b1;
    en_cnt = 0;
    ticks(6);
    chk("rel_early", int'(bus.o_cnt_en), 0);
    tick();
    chk("rel_exact", int'(bus.o_cnt_en), 1);
    ticks(60);
    chk("rel_count", en_cnt, 1);
    chk("rel_mode", int'(bus.o_mode), 0);
    set_btn(3'b000);
    ticks(10);

    chk("en_clr_overlap", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Control front-end for the 3-bit LED counter.
- Conditions three raw push-buttons: 2-flop synchronizer, debounce filter, rising-edge detector per button.
- A mode FSM issues single-cycle enable/direction/clear strobes to the counter datapath.
- The counter datapath holds the count. This block only sequences it: manual step, auto-run up, auto-run down.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized input must differ from its filtered level before the filtered level flips. Range ≥2. Board builds override with a large value.
- AUTO_DIV, 8: clock cycles between auto-run enable pulses. Range ≥2.

Ports:
- i_clk  in  1  system clock; all state on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_btn_step  in  1  raw step button, asynchronous, active-high.
- i_btn_mode  in  1  raw mode button, asynchronous, active-high.
- i_btn_clr  in  1  raw clear button, asynchronous, active-high.
- o_cnt_en  out  1  one-cycle count strobe to counter.
- o_cnt_up  out  1  count direction: 1 = up, 0 = down.
- o_cnt_clr  out  1  one-cycle synchronous clear strobe to counter.
- o_mode  out  2  current mode: 00 STEP, 01 RUN_UP, 10 RUN_DOWN.

Behaviour:
- Reset (asynchronous assert, synchronous use after deassert):
  - o_cnt_en=0, o_cnt_clr=0, o_mode=00, o_cnt_up=1.
  - Sync flops, filtered levels, edge registers, debounce counters and prescaler all cleared to 0.
- Conditioning, identical per button:
  - s1 <= raw; s2 <= s1.
  - Debounce counter increments while s2 != filtered level and resets to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, the filtered level toggles and the counter clears.
  - Press pulse = filtered & ~filtered_q.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no pulse.
- Latency: raw rising edge first sampled at edge k → resulting o_cnt_en/o_cnt_clr, or mode change, registered at edge k+DEBOUNCE_CYCLES+2. This is exact; all outputs are registered.
- Priority of press pulses in the same cycle: clr > mode > step. Losing pulses are discarded, not queued.
- FSM (o_mode is the state register):
  - STEP: step press → o_cnt_en=1 for one cycle. Mode press → RUN_UP.
  - RUN_UP: prescaler counts 0..AUTO_DIV-1. On wrap, o_cnt_en=1 for one cycle. Step presses ignored. Mode press → RUN_DOWN.
  - RUN_DOWN: same as RUN_UP with o_cnt_up=0. Mode press → STEP.
  - Clr press in any state: o_cnt_clr=1 for one cycle, o_cnt_en=0 that cycle, next state STEP, prescaler cleared.
  - Illegal state 11 → STEP on next edge; no strobes issued.
- Prescaler clears on every state change.
  - First auto pulse occurs AUTO_DIV cycles after the state-change edge.
  - Auto pulses are then periodic every AUTO_DIV cycles.
- o_cnt_up:
  - Registered with the state: 1 in STEP and RUN_UP, 0 in RUN_DOWN.
  - Changes on the same edge as o_mode, never mid-pulse.
- o_cnt_en and o_cnt_clr are never high in the same cycle.
- A button held long produces exactly one pulse. A release is filtered too but generates no pulse.
- Reset mid-operation: outputs drop immediately.
  - A button still held at reset release is seen as a new press after the full latency (filtered level restarts at 0).

Test Plan:
- Reset, 10 clean step presses (each ≥20 cycles high, ≥20 low) → exactly 10 o_cnt_en pulses; o_cnt_up=1; first pulse 6 edges after first sampled press.
- Step pulse of 2 cycles, then a bouncing 1/0 pattern with every high run ≤3 cycles → 0 o_cnt_en pulses; o_mode stays 00.
- One mode press, then run 80 cycles → o_mode=01, 10 o_cnt_en pulses spaced 8 cycles, o_cnt_up=1. Step presses during this window add no pulses.
- Second mode press → o_mode=10, o_cnt_up=0, pulses continue every 8 cycles. Third press → o_mode=00, no auto pulses for 50 cycles.
- In RUN_UP, assert mode and clr on the same cycle → one o_cnt_clr pulse, o_cnt_en low that cycle, o_mode=00 (mode press discarded).
- Hold step, pulse i_reset_n low for 3 cycles mid-RUN_DOWN → all outputs 0/00/up=1 during reset. After release, one o_cnt_en pulse 6 edges later, and none further while held.
